// File: rtl/intc_pkg.sv
// Shared types and constants for the four-line interrupt controller.
// Holds the FSM encoding and the fixed-priority level picker.
package intc_pkg;

  localparam int NUM_IRQ = 4;
  localparam int LVL_W   = 2;

  typedef enum logic [1:0] {
    INTC_IDLE    = 2'b00,
    INTC_REQUEST = 2'b01,
    INTC_SERVICE = 2'b10
  } intcState_t;

  // Lowest set index wins; bit 0 is the most urgent line.
  function automatic logic [LVL_W-1:0] pickLevel(
    input logic [NUM_IRQ-1:0] req
  );
    logic [LVL_W-1:0] lvl;
    lvl = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (req[i]) lvl = LVL_W'(i);
    end
    return lvl;
  endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// Multi-flop synchroniser for one raw interrupt line.
// Emits a single-cycle pulse on each rising edge seen at the last stage.
module irq_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic CLK,
  input  logic Reset,
  input  logic irqIn,
  output logic rise
);

  logic [SYNC_STAGES-1:0] syncQ;
  logic                   lastQ;

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      syncQ <= '0;
      lastQ <= 1'b0;
    end else begin
      syncQ <= {syncQ[SYNC_STAGES-2:0], irqIn};
      lastQ <= syncQ[SYNC_STAGES-1];
    end
  end

  assign rise = syncQ[SYNC_STAGES-1] & ~lastQ;

endmodule

// File: rtl/interrupt_controller.sv
// Four-line prioritised interrupt controller in front of the datapath.
// Latches edges as pending, masks them and tracks one in-service level.
module interrupt_controller
  import intc_pkg::*;
#(
  parameter int          SYNC_STAGES = 2,
  parameter logic [15:0] VEC_BASE    = 16'h0040,
  parameter logic [15:0] VEC_STRIDE  = 16'h0004
) (
  input  logic               CLK,
  input  logic               Reset,
  input  logic [NUM_IRQ-1:0] irqIn,
  input  logic               maskWrite,
  input  logic [NUM_IRQ-1:0] maskData,
  input  logic               intAck,
  input  logic               intDone,
  output logic               intr,
  output logic               intLvl1,
  output logic               intLvl0,
  output logic [15:0]        intVector,
  output logic [NUM_IRQ-1:0] pending,
  output logic [NUM_IRQ-1:0] mask,
  output logic               inService
);

  intcState_t         state;
  logic [LVL_W-1:0]   level;
  logic [LVL_W-1:0]   selLvl;
  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] active;
  logic [NUM_IRQ-1:0] clrMask;
  logic [15:0]        selVec;

  for (genvar i = 0; i < NUM_IRQ; i++) begin : gSync
    irq_sync_edge #(
      .SYNC_STAGES(SYNC_STAGES)
    ) uSync (
      .CLK  (CLK),
      .Reset(Reset),
      .irqIn(irqIn[i]),
      .rise (rise[i])
    );
  end

  assign active = pending & mask;
  assign selLvl = pickLevel(active);
  assign selVec = VEC_BASE + VEC_STRIDE * 16'(selLvl);

  always_comb begin
    clrMask = '0;
    if (state == INTC_REQUEST && intAck) begin
      clrMask[level] = 1'b1;
    end
  end

  // A new edge on the bit being cleared survives the clear.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      pending <= '0;
      mask    <= '0;
    end else begin
      pending <= (pending & ~clrMask) | rise;
      if (maskWrite) mask <= maskData;
    end
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state     <= INTC_IDLE;
      intr      <= 1'b0;
      level     <= '0;
      intVector <= VEC_BASE;
      inService <= 1'b0;
    end else begin
      unique case (state)
        INTC_IDLE: begin
          if (|active) begin
            state     <= INTC_REQUEST;
            level     <= selLvl;
            intVector <= selVec;
            intr      <= 1'b1;
          end
        end
        INTC_REQUEST: begin
          if (intAck) begin
            state     <= INTC_SERVICE;
            intr      <= 1'b0;
            inService <= 1'b1;
          end
        end
        INTC_SERVICE: begin
          if (intDone) begin
            state     <= INTC_IDLE;
            inService <= 1'b0;
          end
        end
        default: state <= INTC_IDLE;
      endcase
    end
  end

  assign {intLvl1, intLvl0} = level;

endmodule
